// File: rtl/cpu_clock_ctrl.sv
// Clock/enable controller for a single-cycle CPU: free-run divider, debounced
// single-step button and PC breakpoint with resume-skip.
module cpu_clock_ctrl #(
  parameter int RUN_DIV  = 25000000,
  parameter int DEBOUNCE = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  input  logic [7:0]  pc,
  output logic        cpu_en,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] step_count
);

  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BREAK = 2'b11
  } state_e;

  logic [1:0]       run_sync_q, btn_sync_q;
  logic             run_s, btn_s;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             btn_d_q, btn_d_d;
  logic             press_q, press_d;
  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             skip_q, skip_d;
  logic [15:0]      step_count_q, step_count_d;
  logic             tick, bp_hit;

  assign run_s = run_sync_q[1];
  assign btn_s = btn_sync_q[1];

  // Debounce: btn_d follows btn_s only after DEBOUNCE consecutive differing cycles.
  always_comb begin
    db_cnt_d = '0;
    btn_d_d  = btn_d_q;
    press_d  = 1'b0;
    if (btn_s != btn_d_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_d_d = btn_s;
        press_d = btn_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign tick   = (div_q == DIV_LAST);
  assign bp_hit = bp_en && (pc == bp_addr) && !skip_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    skip_d  = skip_q;
    cpu_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_s) begin
          state_d = RUN;
          div_d   = '0;
        end else if (press_q) begin
          state_d = STEP;
        end
      end
      STEP: begin
        cpu_en  = 1'b1;
        state_d = IDLE;
      end
      RUN: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (!run_s) begin
          state_d = IDLE;
        end else if (tick && bp_hit) begin
          state_d = BREAK;
        end else if (tick) begin
          cpu_en = 1'b1;
          skip_d = 1'b0;
        end
      end
      BREAK: begin
        if (!run_s) begin
          state_d = IDLE;
        end else if (press_q) begin
          // Resume: let the instruction sitting at the breakpoint execute once.
          state_d = RUN;
          div_d   = '0;
          skip_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign step_count_d = step_count_q + {15'd0, cpu_en};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_sync_q   <= '0;
      btn_sync_q   <= '0;
      db_cnt_q     <= '0;
      btn_d_q      <= 1'b0;
      press_q      <= 1'b0;
      state_q      <= IDLE;
      div_q        <= '0;
      skip_q       <= 1'b0;
      step_count_q <= '0;
    end else begin
      run_sync_q   <= {run_sync_q[0], run_sw};
      btn_sync_q   <= {btn_sync_q[0], step_btn};
      db_cnt_q     <= db_cnt_d;
      btn_d_q      <= btn_d_d;
      press_q      <= press_d;
      state_q      <= state_d;
      div_q        <= div_d;
      skip_q       <= skip_d;
      step_count_q <= step_count_d;
    end
  end

  assign state      = state_q;
  assign halted     = (state_q == BREAK);
  assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl: directed vector table, hand sequences for
// step/breakpoint/reset, random run against a reference model, counter wrap.
module tb_cpu_clock_ctrl;

  localparam int RUN_DIV  = 4;
  localparam int DEBOUNCE = 3;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_BREAK = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run_sw, step_btn, bp_en;
  logic [7:0]  bp_addr, pc;
  logic        cpu_en, halted;
  logic [1:0]  state;
  logic [15:0] step_count;

  logic        rst2, run_sw2;
  logic        cpu_en2, halted2;
  logic [1:0]  state2;
  logic [15:0] step_count2;

  cpu_clock_ctrl #(.RUN_DIV(RUN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_en(cpu_en), .halted(halted), .state(state), .step_count(step_count)
  );

  // Fastest divider so the 16-bit counter can be wrapped in reasonable time.
  cpu_clock_ctrl #(.RUN_DIV(1), .DEBOUNCE(DEBOUNCE)) dut_wrap (
    .clk(clk), .rst(rst2), .run_sw(run_sw2), .step_btn(1'b0),
    .bp_en(1'b0), .bp_addr(8'd0), .pc(8'd0),
    .cpu_en(cpu_en2), .halted(halted2), .state(state2), .step_count(step_count2)
  );

  int checks = 0;
  int errors = 0;
  bit wrap_done = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  typedef struct {
    logic        run_sw;
    logic [1:0]  st;
    logic        en;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t vec(logic r, logic [1:0] s, logic e, logic [15:0] c);
    vec_t v;
    v.run_sw = r; v.st = s; v.en = e; v.cnt = c;
    return v;
  endfunction

  // Reference model: behaviour stated as rules on modes, phases and delays.
  int          m_mode, m_phase, m_stable;
  bit          m_skip, m_btn_d, m_press;
  int unsigned m_count;
  bit          rq[$];
  bit          bq[$];

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_stable = 0;
    m_skip = 0; m_btn_d = 0; m_press = 0; m_count = 0;
    rq = '{0, 0};
    bq = '{0, 0};
  endtask

  function automatic bit model_en();
    bit hit;
    hit = bp_en && (pc == bp_addr) && !m_skip;
    return (m_mode == 2) || (m_mode == 1 && rq[0] && m_phase == RUN_DIV - 1 && !hit);
  endfunction

  task automatic model_step(input bit en);
    bit rs, bs, tick, hit, pr;
    rs = rq[0]; bs = bq[0];
    tick = (m_phase == RUN_DIV - 1);
    hit  = bp_en && (pc == bp_addr) && !m_skip;
    pr   = m_press;
    if (en) m_count = (m_count + 1) % 65536;
    case (m_mode)
      0: if (rs) begin m_mode = 1; m_phase = 0; end
         else if (pr) m_mode = 2;
      2: m_mode = 0;
      1: if (!rs) m_mode = 0;
         else if (tick && hit) m_mode = 3;
         else begin
           if (tick) m_skip = 0;
           m_phase = (m_phase + 1) % RUN_DIV;
         end
      default: if (!rs) m_mode = 0;
         else if (pr) begin m_mode = 1; m_phase = 0; m_skip = 1; end
    endcase
    m_press = 0;
    if (bs != m_btn_d) begin
      m_stable++;
      if (m_stable == DEBOUNCE) begin
        m_btn_d = bs; m_stable = 0; m_press = bs;
      end
    end else begin
      m_stable = 0;
    end
    rq.push_back(run_sw); void'(rq.pop_front());
    bq.push_back(step_btn); void'(bq.pop_front());
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit chk);
    rst = 1'b0; run_sw = 1'b0; step_btn = 1'b0;
    bp_en = 1'b0; bp_addr = 8'd0; pc = 8'd0;
    repeat (2) @(negedge clk);
    if (chk) begin
      check("reset_state", 32'(state), 32'(S_IDLE));
      check("reset_cpu_en", 32'(cpu_en), 32'd0);
      check("reset_halted", 32'(halted), 32'd0);
      check("reset_step_count", 32'(step_count), 32'd0);
    end
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    vec_t tbl[$];
    int   n, n_step, p, first_pc;
    bit   upd, hit, left;

    // Start of free-run, 5 ticks, then run_sw dropped so run_s falls on a tick.
    repeat (3) tbl.push_back(vec(1, S_IDLE, 0, 0));
    repeat (3) tbl.push_back(vec(1, S_RUN, 0, 0));
    tbl.push_back(vec(1, S_RUN, 1, 0));
    for (int k = 1; k <= 4; k++) begin
      repeat (3) tbl.push_back(vec(1, S_RUN, 0, 16'(k)));
      tbl.push_back(vec(1, S_RUN, 1, 16'(k)));
    end
    tbl.push_back(vec(1, S_RUN, 0, 5));
    repeat (3) tbl.push_back(vec(0, S_RUN, 0, 5));
    tbl.push_back(vec(0, S_IDLE, 0, 5));

    do_reset(1);
    foreach (tbl[i]) begin
      run_sw = tbl[i].run_sw;
      #1;
      check($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      check($sformatf("vec%0d_cpu_en", i), 32'(cpu_en), 32'(tbl[i].en));
      check($sformatf("vec%0d_count", i), 32'(step_count), 32'(tbl[i].cnt));
      cycle();
    end

    // Bouncing button then a solid press: one STEP, one pulse.
    n = 0; n_step = 0;
    for (int c = 0; c < 22; c++) begin
      step_btn = (c < 10) ? ((c < 4) ? ((c % 2) == 0) : 1'b1) : 1'b0;
      #1;
      if (cpu_en) n++;
      if (state == S_STEP) n_step++;
      cycle();
    end
    check("step_pulses", 32'(n), 32'd1);
    check("step_cycles", 32'(n_step), 32'd1);
    check("step_count_after_step", 32'(step_count), 32'd6);
    check("step_back_idle", 32'(state), 32'(S_IDLE));

    // Breakpoint at 0x05 with pc advancing once per pulse.
    bp_en = 1'b1; bp_addr = 8'h05; pc = 8'h00; run_sw = 1'b1;
    n = 0; hit = 0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (halted) begin hit = 1; break; end
      upd = cpu_en;
      if (upd) n++;
      cycle();
      if (upd) pc = (pc + 8'd1) & 8'h07;
    end
    check("bp_reached", 32'(hit), 32'd1);
    check("bp_pulses", 32'(n), 32'd5);
    check("bp_state", 32'(state), 32'(S_BREAK));
    check("bp_pc", 32'(pc), 32'h05);
    check("bp_step_count", 32'(step_count), 32'd11);
    p = 0;
    repeat (8) begin
      if (cpu_en) p++;
      cycle();
    end
    check("break_holds_no_pulse", 32'(p), 32'd0);
    check("break_holds_halted", 32'(halted), 32'd1);

    // Resume with a press: the breakpoint instruction runs once, breaks again later.
    n = 0; hit = 0; left = 0; first_pc = -1;
    for (int c = 0; c < 400; c++) begin
      step_btn = (c < 6);
      #1;
      if (state != S_BREAK) left = 1;
      if (left && halted) begin hit = 1; break; end
      upd = cpu_en;
      if (upd) begin
        if (n == 0) first_pc = int'(pc);
        n++;
      end
      cycle();
      if (upd) pc = (pc + 8'd1) & 8'h07;
    end
    step_btn = 1'b0;
    check("resume_rebreak", 32'(hit), 32'd1);
    check("resume_first_pc", 32'(first_pc), 32'h05);
    check("resume_pulses", 32'(n), 32'd8);
    check("resume_pc", 32'(pc), 32'h05);
    check("resume_step_count", 32'(step_count), 32'd19);

    // Random traffic against the reference model.
    do_reset(0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) run_sw = ~run_sw;
      if ($urandom_range(5) == 0) step_btn = ~step_btn;
      bp_en = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) bp_addr = 8'($urandom_range(3));
      pc = 8'($urandom_range(3));
      #1;
      upd = model_en();
      check($sformatf("rand%0d_cpu_en", c), 32'(cpu_en), 32'(upd));
      check($sformatf("rand%0d_state", c), 32'(state), 32'(m_mode));
      check($sformatf("rand%0d_halted", c), 32'(halted), 32'(m_mode == 3));
      check($sformatf("rand%0d_count", c), 32'(step_count), m_count);
      @(posedge clk);
      model_step(upd);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of RUN, then re-entry only through IDLE.
    do_reset(0);
    run_sw = 1'b1;
    repeat (9) cycle();
    check("pre_rst_run", 32'(state), 32'(S_RUN));
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_cpu_en", 32'(cpu_en), 32'd0);
    check("async_rst_halted", 32'(halted), 32'd0);
    check("async_rst_count", 32'(step_count), 32'd0);
    p = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_en || state != S_IDLE) p++;
    end
    check("rst_held_quiet", 32'(p), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_release_idle", 32'(state), 32'(S_IDLE));
    cycle(); cycle();
    #1;
    check("reentry_still_idle", 32'(state), 32'(S_IDLE));
    cycle();
    #1;
    check("reentry_run", 32'(state), 32'(S_RUN));

    wait (wrap_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // 65536 pulses on the RUN_DIV=1 instance: counter reads 0xFFFF then 0x0000.
  initial begin
    int n;
    bit seen, done;
    n = 0; seen = 0; done = 0;
    rst2 = 1'b0; run_sw2 = 1'b0;
    repeat (2) @(negedge clk);
    rst2 = 1'b1; run_sw2 = 1'b1;
    for (int c = 0; c < 70000 && !done; c++) begin
      #1;
      if (n == 65535 && !seen) begin
        check("wrap_ffff", 32'(step_count2), 32'h0000FFFF);
        seen = 1;
      end
      if (n == 65536) begin
        check("wrap_zero", 32'(step_count2), 32'd0);
        done = 1;
      end else begin
        if (cpu_en2) n++;
        cycle();
      end
    end
    if (!done) check("wrap_timeout", 32'(n), 32'd65536);
    wrap_done = 1'b1;
  end

endmodule
